// File: rtl/loom_irq_pkg.sv
// Shared types and limits for the emulator-to-host interrupt bridge.
package loom_irq_pkg;

    localparam int XDMA_MAX_IRQ = 16;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        ASSERTED = 2'd2,
        DEASSERT = 2'd3
    } irq_state_e;

    // XDMA sees the request line high while we wait for the first ack and while legacy INTx is asserted
    function automatic logic state_drives_req(input irq_state_e st);
        return (st == REQ) || (st == ASSERTED);
    endfunction

endpackage

// File: rtl/loom_irq_vec_fsm.sv
// One interrupt vector: CDC synchronizer, rising-edge detect, pending latch and XDMA req/ack FSM.
module loom_irq_vec_fsm
    import loom_irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic irq_i,
    input  logic irq_en_i,
    input  logic msi_enable_i,
    input  logic usr_irq_ack_i,
    output logic usr_irq_req_o,
    output logic irq_pending_o,
    output logic irq_busy_o,
    output logic coalesce_hit_o
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   s_d_r;
    logic [SYNC_STAGES:0]   hist_valid_r;
    logic                   pending_r;
    logic                   req_r;
    logic                   busy_r;
    irq_state_e             state_r;
    irq_state_e             state_next_s;
    logic                   s_s;
    logic                   rise_s;
    logic                   set_s;

    // An edge only counts once s_d holds a real sample, so a level held high across reset is not re-reported
    assign s_s            = sync_r[SYNC_STAGES-1];
    assign rise_s         = s_s & ~s_d_r & hist_valid_r[SYNC_STAGES];
    assign set_s          = rise_s & irq_en_i;
    assign coalesce_hit_o = set_s & pending_r;

    // Synchronizer chain, edge history and history-valid tracking
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_r       <= '0;
            s_d_r        <= 1'b0;
            hist_valid_r <= '0;
        end else begin
            sync_r       <= {sync_r[SYNC_STAGES-2:0], irq_i};
            s_d_r        <= s_s;
            hist_valid_r <= {hist_valid_r[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Next-state decode of the XDMA handshake
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (pending_r) state_next_s = REQ;
                else           state_next_s = IDLE;
            end
            REQ: begin
                if (usr_irq_ack_i) begin
                    if (msi_enable_i) state_next_s = IDLE;
                    else              state_next_s = ASSERTED;
                end else begin
                    state_next_s = REQ;
                end
            end
            ASSERTED: begin
                if (!s_s) state_next_s = DEASSERT;
                else      state_next_s = ASSERTED;
            end
            DEASSERT: begin
                if (usr_irq_ack_i) state_next_s = IDLE;
                else               state_next_s = DEASSERT;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, pending latch and registered status outputs
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r   <= IDLE;
            pending_r <= 1'b0;
            req_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            req_r   <= state_drives_req(state_next_s);
            busy_r  <= (state_next_s != IDLE);
            if (set_s) begin
                pending_r <= 1'b1;
            end else if ((state_r == IDLE) && (state_next_s == REQ)) begin
                pending_r <= 1'b0;
            end else begin
                pending_r <= pending_r;
            end
        end
    end

    assign usr_irq_req_o = req_r;
    assign irq_pending_o = pending_r;
    assign irq_busy_o    = busy_r;

endmodule

// File: rtl/loom_irq_msi_bridge.sv
// Bridges emulation-core level interrupts onto the XDMA usr_irq req/ack pins, MSI or legacy INTx.
module loom_irq_msi_bridge
    import loom_irq_pkg::*;
#(
    parameter int N_IRQ       = XDMA_MAX_IRQ,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_IRQ-1:0]     irq_i,
    input  logic [N_IRQ-1:0]     irq_en_i,
    input  logic                 msi_enable_i,
    output logic [N_IRQ-1:0]     usr_irq_req_o,
    input  logic [N_IRQ-1:0]     usr_irq_ack_i,
    output logic [N_IRQ-1:0]     irq_pending_o,
    output logic [N_IRQ-1:0]     irq_busy_o,
    output logic [CNT_WIDTH-1:0] coalesce_cnt_o,
    input  logic                 cnt_clr_i
);

    logic [N_IRQ-1:0]     hit_s;
    logic [CNT_WIDTH-1:0] cnt_r;

    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_vec
        loom_irq_vec_fsm #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_vec (
            .clk_i          (clk_i),
            .rst_i          (rst_i),
            .irq_i          (irq_i[gi]),
            .irq_en_i       (irq_en_i[gi]),
            .msi_enable_i   (msi_enable_i),
            .usr_irq_ack_i  (usr_irq_ack_i[gi]),
            .usr_irq_req_o  (usr_irq_req_o[gi]),
            .irq_pending_o  (irq_pending_o[gi]),
            .irq_busy_o     (irq_busy_o[gi]),
            .coalesce_hit_o (hit_s[gi])
        );
    end

    // Saturating count of cycles in which some edge merged into an already-pending vector
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_r <= '0;
        end else if (cnt_clr_i) begin
            cnt_r <= '0;
        end else if ((|hit_s) && (cnt_r != {CNT_WIDTH{1'b1}})) begin
            cnt_r <= cnt_r + CNT_WIDTH'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign coalesce_cnt_o = cnt_r;

endmodule

// File: tb/tb_loom_irq_msi_bridge.sv
// Self-checking bench for loom_irq_msi_bridge: randomized scenarios against timing rules derived from the handshake description.
module tb_loom_irq_msi_bridge;

    localparam int N        = 16;
    localparam int SYNC     = 2;
    localparam int CW       = 16;
    localparam int REQ_LAT  = SYNC + 2;
    localparam int DROP_LAT = SYNC + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  irq = '0;
    logic [N-1:0]  en  = '0;
    logic [N-1:0]  ack = '0;
    logic          msi = 1'b1;
    logic          cnt_clr = 1'b0;
    logic [N-1:0]  req;
    logic [N-1:0]  pend;
    logic [N-1:0]  busy;
    logic [CW-1:0] cnt;

    int n_cmp = 0;
    int n_mis = 0;

    loom_irq_msi_bridge #(.N_IRQ(N), .SYNC_STAGES(SYNC), .CNT_WIDTH(CW)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .irq_i          (irq),
        .irq_en_i       (en),
        .msi_enable_i   (msi),
        .usr_irq_req_o  (req),
        .usr_irq_ack_i  (ack),
        .irq_pending_o  (pend),
        .irq_busy_o     (busy),
        .coalesce_cnt_o (cnt),
        .cnt_clr_i      (cnt_clr)
    );

    always #4 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Cycles until req[v] reaches lvl; 20 means it never did
    task automatic wait_level(input int v, input logic lvl, output int lat);
        lat = 0;
        while (req[v] !== lvl && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pulse_ack(input logic [N-1:0] m);
        ack = m;
        @(negedge clk);
        ack = '0;
    endtask

    function automatic logic [N-1:0] onehot(input int v);
        logic [N-1:0] m;
        m = '0;
        m[v] = 1'b1;
        return m;
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        irq = 16'hFFFF;
        en  = 16'hFFFF;
        cyc(3);
        n_cmp++; if (req !== 16'h0000) begin n_mis++; $display("FAIL reset_req: got %h want 0000", req); end
        n_cmp++; if (pend !== 16'h0000) begin n_mis++; $display("FAIL reset_pending: got %h want 0000", pend); end
        n_cmp++; if (busy !== 16'h0000) begin n_mis++; $display("FAIL reset_busy: got %h want 0000", busy); end
        n_cmp++; if (cnt !== 16'h0000) begin n_mis++; $display("FAIL reset_cnt: got %h want 0000", cnt); end
        irq = '0;
        en  = '0;
        rst = 1'b0;
        cyc(4);
    endtask

    task automatic test_msi_single();
        int v, lat, d;
        for (int it = 0; it < 3; it++) begin
            v   = (it == 0) ? 0 : int'($urandom_range(0, N - 1));
            msi = 1'b1;
            en  = onehot(v);
            irq[v] = 1'b1;
            wait_level(v, 1'b1, lat);
            n_cmp++; if (lat !== REQ_LAT) begin n_mis++; $display("FAIL msi_latency v%0d: got %0d want %0d", v, lat, REQ_LAT); end
            d = (it == 0) ? 3 : int'($urandom_range(1, 5));
            cyc(d);
            n_cmp++; if (req[v] !== 1'b1) begin n_mis++; $display("FAIL msi_req_held v%0d: got %b want 1", v, req[v]); end
            pulse_ack(onehot(v));
            n_cmp++; if (req[v] !== 1'b0) begin n_mis++; $display("FAIL msi_req_after_ack v%0d: got %b want 0", v, req[v]); end
            n_cmp++; if (busy[v] !== 1'b0) begin n_mis++; $display("FAIL msi_busy_after_ack v%0d: got %b want 0", v, busy[v]); end
            irq[v] = 1'b0;
            cyc(4);
        end
    endtask

    task automatic test_legacy();
        int lat;
        msi   = 1'b0;
        en    = onehot(3);
        irq[3] = 1'b1;
        wait_level(3, 1'b1, lat);
        n_cmp++; if (lat !== REQ_LAT) begin n_mis++; $display("FAIL legacy_latency: got %0d want %0d", lat, REQ_LAT); end
        pulse_ack(onehot(3));
        n_cmp++; if (req[3] !== 1'b1) begin n_mis++; $display("FAIL legacy_req_after_ack: got %b want 1", req[3]); end
        msi = 1'b1;
        cyc($urandom_range(1, 6));
        n_cmp++; if (req[3] !== 1'b1) begin n_mis++; $display("FAIL legacy_asserted_hold: got %b want 1", req[3]); end
        irq[3] = 1'b0;
        wait_level(3, 1'b0, lat);
        n_cmp++; if (lat !== DROP_LAT) begin n_mis++; $display("FAIL legacy_drop_latency: got %0d want %0d", lat, DROP_LAT); end
        n_cmp++; if (busy[3] !== 1'b1) begin n_mis++; $display("FAIL legacy_busy_deassert: got %b want 1", busy[3]); end
        pulse_ack(onehot(3));
        n_cmp++; if (busy[3] !== 1'b0) begin n_mis++; $display("FAIL legacy_busy_final: got %b want 0", busy[3]); end
        cyc(2);
    endtask

    task automatic test_coalesce();
        int lat, np;
        msi = 1'b1;
        en  = onehot(5);
        cnt_clr = 1'b1;
        cyc(1);
        cnt_clr = 1'b0;
        irq[5] = 1'b1;
        wait_level(5, 1'b1, lat);
        irq[5] = 1'b0;
        cyc(4);
        np = $urandom_range(2, 5);
        for (int p = 0; p < np; p++) begin
            irq[5] = 1'b1; cyc(4);
            irq[5] = 1'b0; cyc(4);
        end
        n_cmp++; if (pend[5] !== 1'b1) begin n_mis++; $display("FAIL coalesce_pending: got %b want 1", pend[5]); end
        n_cmp++; if (cnt !== CW'(np - 1)) begin n_mis++; $display("FAIL coalesce_cnt: got %0d want %0d", cnt, np - 1); end
        pulse_ack(onehot(5));
        n_cmp++; if (req[5] !== 1'b0) begin n_mis++; $display("FAIL coalesce_gap: got %b want 0", req[5]); end
        cyc(1);
        n_cmp++; if (req[5] !== 1'b1) begin n_mis++; $display("FAIL coalesce_rereq: got %b want 1", req[5]); end
        n_cmp++; if (pend[5] !== 1'b0) begin n_mis++; $display("FAIL coalesce_pending_cleared: got %b want 0", pend[5]); end
        pulse_ack(onehot(5));
        cyc(2);
    endtask

    task automatic test_masking();
        int lat;
        msi = 1'b1;
        en  = onehot(2);
        irq[7] = 1'b1; cyc(4);
        irq[7] = 1'b0; cyc(6);
        n_cmp++; if (req[7] !== 1'b0) begin n_mis++; $display("FAIL mask_req7: got %b want 0", req[7]); end
        n_cmp++; if (pend[7] !== 1'b0) begin n_mis++; $display("FAIL mask_pending7: got %b want 0", pend[7]); end
        irq[2] = 1'b1;
        wait_level(2, 1'b1, lat);
        n_cmp++; if (lat !== REQ_LAT) begin n_mis++; $display("FAIL mask_latency2: got %0d want %0d", lat, REQ_LAT); end
        en[2] = 1'b0;
        cyc($urandom_range(2, 6));
        n_cmp++; if (req[2] !== 1'b1) begin n_mis++; $display("FAIL mask_req2_held: got %b want 1", req[2]); end
        pulse_ack(onehot(2));
        n_cmp++; if (req[2] !== 1'b0) begin n_mis++; $display("FAIL mask_req2_done: got %b want 0", req[2]); end
        irq[2] = 1'b0; cyc(4);
        irq[2] = 1'b1; cyc(8);
        n_cmp++; if (pend[2] !== 1'b0 || req[2] !== 1'b0) begin n_mis++; $display("FAIL mask_disabled2: got pend %b req %b want 0 0", pend[2], req[2]); end
        irq[2] = 1'b0;
        cyc(4);
    endtask

    task automatic test_simultaneous();
        int lat;
        msi = 1'b1;
        en  = 16'h0243;
        pulse_ack(onehot(9));
        n_cmp++; if (busy[9] !== 1'b0 || req[9] !== 1'b0) begin n_mis++; $display("FAIL spurious_ack: got busy %b req %b want 0 0", busy[9], req[9]); end
        irq[1:0] = 2'b11;
        wait_level(0, 1'b1, lat);
        n_cmp++; if (lat !== REQ_LAT || req[1] !== 1'b1) begin n_mis++; $display("FAIL dual_req: got lat %0d req1 %b want %0d 1", lat, req[1], REQ_LAT); end
        pulse_ack(16'h0003);
        n_cmp++; if (req[1:0] !== 2'b00 || busy[1:0] !== 2'b00) begin n_mis++; $display("FAIL dual_ack: got req %b busy %b want 00 00", req[1:0], busy[1:0]); end
        irq[1:0] = 2'b00;
        cyc(4);
        irq[6] = 1'b1;
        wait_level(6, 1'b1, lat);
        irq[6] = 1'b0; cyc(4);
        irq[6] = 1'b1; cyc(4);
        irq[6] = 1'b0; cyc(4);
        irq[6] = 1'b1;
        cyc(SYNC);
        cnt_clr = 1'b1;
        cyc(1);
        cnt_clr = 1'b0;
        n_cmp++; if (cnt !== 16'h0000) begin n_mis++; $display("FAIL clr_priority: got %0d want 0", cnt); end
        irq[6] = 1'b0; cyc(4);
        irq[6] = 1'b1; cyc(4);
        n_cmp++; if (cnt !== 16'h0001) begin n_mis++; $display("FAIL cnt_after_clr: got %0d want 1", cnt); end
        pulse_ack(onehot(6));
        cyc(1);
        pulse_ack(onehot(6));
        irq[6] = 1'b0;
        cyc(4);
    endtask

    task automatic test_reset_midop();
        int lat;
        msi = 1'b1;
        en  = onehot(4);
        irq[4] = 1'b1;
        wait_level(4, 1'b1, lat);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (req !== 16'h0000) begin n_mis++; $display("FAIL reset_async_req: got %h want 0000", req); end
        @(negedge clk);
        rst = 1'b0;
        cyc(10);
        n_cmp++; if (req[4] !== 1'b0 || pend[4] !== 1'b0) begin n_mis++; $display("FAIL reset_held_level: got req %b pend %b want 0 0", req[4], pend[4]); end
        irq[4] = 1'b0; cyc(4);
        irq[4] = 1'b1;
        wait_level(4, 1'b1, lat);
        n_cmp++; if (lat !== REQ_LAT) begin n_mis++; $display("FAIL reset_rearm_latency: got %0d want %0d", lat, REQ_LAT); end
        pulse_ack(onehot(4));
        irq[4] = 1'b0;
        cyc(4);
    endtask

    task automatic test_back_to_back();
        int v, lat;
        logic mode;
        en = 16'hFFFF;
        for (int it = 0; it < 6; it++) begin
            v    = $urandom_range(0, N - 1);
            mode = 1'($urandom_range(0, 1));
            msi  = mode;
            irq[v] = 1'b1;
            wait_level(v, 1'b1, lat);
            n_cmp++; if (lat !== REQ_LAT) begin n_mis++; $display("FAIL b2b_latency v%0d: got %0d want %0d", v, lat, REQ_LAT); end
            cyc($urandom_range(0, 4));
            pulse_ack(onehot(v));
            n_cmp++; if (req[v] !== !mode) begin n_mis++; $display("FAIL b2b_after_ack v%0d msi %b: got %b want %b", v, mode, req[v], !mode); end
            irq[v] = 1'b0;
            if (!mode) begin
                wait_level(v, 1'b0, lat);
                n_cmp++; if (lat !== DROP_LAT) begin n_mis++; $display("FAIL b2b_drop v%0d: got %0d want %0d", v, lat, DROP_LAT); end
                pulse_ack(onehot(v));
            end
            cyc(3);
            n_cmp++; if (busy[v] !== 1'b0) begin n_mis++; $display("FAIL b2b_idle v%0d: got %b want 0", v, busy[v]); end
        end
    endtask

    initial begin
        test_reset();
        test_msi_single();
        test_legacy();
        test_coalesce();
        test_masking();
        test_simultaneous();
        test_reset_midop();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/loom_irq_msi_bridge.md
Name: loom_irq_msi_bridge

Overview:
- Carries emulator interrupts from the device to the host.
- Takes the per-vector level interrupts driven by the emulation core, synchronizes them into the PCIe AXI clock domain, edge-detects them, and runs the XDMA user-interrupt req/ack handshake per vector.
- Sits between the emulation core's irq_o bus and the XDMA usr_irq_req/usr_irq_ack/msi_enable pins.
- Supports MSI handshaking and legacy INTx (assert/deassert) handshaking.

Parameters:
- N_IRQ, 16, number of interrupt vectors (1..16; matches XDMA usr_irq width)
- SYNC_STAGES, 2, flop stages on each irq_i bit (>=2)
- CNT_WIDTH, 16, width of the saturating coalesce counter

Ports:
- clk_i  in  1  PCIe AXI clock (125 MHz)
- rst_i  in  1  asynchronous, active-high reset
- irq_i  in  N_IRQ  level interrupts from the emulation domain; asynchronous to clk_i
- irq_en_i  in  N_IRQ  per-vector enable, quasi-static, clk_i domain
- msi_enable_i  in  1  from XDMA msi_enable; 1 = MSI, 0 = legacy
- usr_irq_req_o  out  N_IRQ  to XDMA usr_irq_req
- usr_irq_ack_i  in  N_IRQ  XDMA usr_irq_ack, one-cycle pulses
- irq_pending_o  out  N_IRQ  edge latched, not yet requested
- irq_busy_o  out  N_IRQ  vector FSM not in IDLE
- coalesce_cnt_o  out  CNT_WIDTH  count of edges merged into an already-pending vector
- cnt_clr_i  in  1  synchronous clear of coalesce_cnt_o

Behaviour:
- Reset (async assert, release on clk_i): all synchronizer flops, edge-history regs, pending, FSM state, usr_irq_req_o, irq_pending_o, irq_busy_o and coalesce_cnt_o go to 0. Reset mid-handshake drops the request with no ack wait.
- Synchronizer: irq_i[i] passes through SYNC_STAGES flops to give s[i]. Registered s_d[i] gives rise[i] = s[i] & ~s_d[i].
- Pending: on rise[i] & irq_en_i[i], pending[i] <= 1 on the next edge. A rise on a disabled vector is discarded.
- Pending is cleared on the edge where the FSM moves IDLE->REQ. If a rise arrives on that same edge, pending stays 1, because set wins over clear.
- Per-vector FSM states:
  - IDLE: req=0. If pending, go to REQ.
  - REQ: req=1. Stay until ack. On ack: if msi_enable_i, go to IDLE; else go to ASSERTED.
  - ASSERTED (legacy only): req=1. When s[i]==0, go to DEASSERT.
  - DEASSERT: req=0. On ack, go to IDLE.
- msi_enable_i is sampled only on the ack edge in REQ. A mode change at any other time never aborts an in-flight handshake.
- usr_irq_req_o[i] is registered and decoded from state: 1 in REQ and ASSERTED.
- Latency: first clock edge sampling irq_i=1 counts as cycle 1; usr_irq_req_o is high after SYNC_STAGES+2 cycles. Minimum back-to-back MSI spacing per vector is 2 cycles after ack (IDLE, then REQ).
- Acks arriving in IDLE or ASSERTED are ignored and do not change state.
- Clearing irq_en_i[i] does not abort a busy FSM. The handshake runs to completion, because XDMA requires the ack pairing. It does block new pending sets.
- Coalesce counter: increments by 1 per cycle in which any vector has rise & en while its pending is already 1. Multiple vectors in one cycle still add only 1. Saturates at all-ones. cnt_clr_i has priority over increment.
- irq_busy_o[i] = (state != IDLE); irq_pending_o = pending.

Decomposition:
- loom_irq_pkg holds:
  - irq_state_e: IDLE=2'd0, REQ=2'd1, ASSERTED=2'd2, DEASSERT=2'd3
  - constant XDMA_MAX_IRQ=16
- One sub-module, loom_irq_vec_fsm, covers a single vector (sync, edge, pending, FSM). The top generates N_IRQ of them plus the shared coalesce counter.

Test Plan:
- MSI single shot: msi_enable_i=1, irq_en_i=16'h0001, irq_i[0] rises -> usr_irq_req_o[0]=1 exactly 4 cycles later; ack pulse 3 cycles after that -> req=0 the next cycle; busy[0]=0.
- Legacy sequence: msi_enable_i=0, irq_i[3] rises, ack -> req held; drop irq_i[3] -> req falls 3 cycles later (2 sync + 1 state); second ack -> IDLE, busy[3]=0.
- Coalescing: while vector 5 is in REQ awaiting ack, pulse irq_i[5] twice (each pulse 4 cycles high / 4 cycles low) -> pending[5]=1, coalesce_cnt_o=1; after ack, a second request issues 2 cycles later.
- Masking: irq_en_i[7]=0 with irq_i[7] pulsed -> no req, pending[7]=0. Clear irq_en_i[2] while it is in REQ -> req stays until ack.
- Simultaneous and spurious: ack on an idle vector -> no change. Ack for vectors 0 and 1 in the same cycle -> both complete independently. cnt_clr_i with a coincident increment -> count reads 0.
- Reset mid-op: assert rst_i while vector 4 is in REQ -> usr_irq_req_o=0 immediately (async). After release with irq_i[4] held high -> no new request until irq_i[4] falls and rises again.
